// File: rtl/core_seq_ctrl_if.sv
// Memory-side handshakes of the RV32I sequencer: instruction and data request/grant/response.
// Latency: none, wires only.
// Backpressure: requests are held by the master until the slave raises gnt.
interface core_seq_ctrl_if;
  logic imem_req;
  logic imem_gnt;
  logic imem_rvalid;
  logic dmem_req;
  logic dmem_we;
  logic dmem_gnt;
  logic dmem_rvalid;

  modport master (
    output imem_req,
    input  imem_gnt,
    input  imem_rvalid,
    output dmem_req,
    output dmem_we,
    input  dmem_gnt,
    input  dmem_rvalid
  );

  modport slave (
    input  imem_req,
    output imem_gnt,
    output imem_rvalid,
    input  dmem_req,
    input  dmem_we,
    output dmem_gnt,
    output dmem_rvalid
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/IWAIT/DECODE/EXEC/MEM/MWAIT/WB with halt, error code, retire count.
// Latency: ALU 5, branch 4, load 7, store 6 cycles with zero-wait memory.
// Backpressure: requests are held until gnt; a response wait longer than TIMEOUT cycles traps to HALT.
module core_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  core_seq_ctrl_if.master      mem,
  output logic                 ir_we,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic                 is_branch,
  input  logic                 is_jump,
  input  logic                 is_illegal,
  input  logic                 br_taken,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic                 rf_we,
  output logic                 halted,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    IWAIT  = 4'd2,
    DECODE = 4'd3,
    EXEC   = 4'd4,
    MEM    = 4'd5,
    MWAIT  = 4'd6,
    WB     = 4'd7,
    HALT   = 4'd8
  } state_t;

  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_IMEM = 2'b10;
  localparam logic [1:0] ERR_DMEM = 2'b11;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            is_mem;
  logic            to_hit;
  logic            retire;
  state_t          after_retire;

  assign is_mem       = is_load | is_store;
  // Last waiting cycle: no response by now means the bus has hung.
  assign to_hit       = (to_cnt == TO_W'(TIMEOUT - 1));
  assign retire       = ((state == EXEC) && !is_mem && is_branch) ||
                        ((state == MWAIT) && mem.dmem_rvalid && is_store) ||
                        (state == WB);
  // A dropped run only takes effect at the retire point, never mid-instruction.
  assign after_retire = run ? FETCH : IDLE;

  // Strobes decode straight off the state flop, qualified only by same-cycle class/response inputs.
  assign mem.imem_req = (state == FETCH);
  assign mem.dmem_req = (state == MEM);
  assign mem.dmem_we  = (state == MEM) && is_store;
  assign ir_we        = (state == IWAIT) && mem.imem_rvalid;
  assign rf_we        = (state == WB);
  assign pc_we        = retire;
  assign pc_sel       = ((state == EXEC) && !is_mem && is_branch && br_taken) ||
                        ((state == WB) && is_jump);
  assign halted       = (state == HALT);

  // Sequencer state, timeout counter, sticky error code and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      to_cnt   <= '0;
      err_code <= 2'b00;
      retired  <= '0;
    end else begin
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (run) state <= FETCH;
        end
        FETCH: begin
          if (mem.imem_gnt) begin
            state  <= IWAIT;
            to_cnt <= '0;
          end
        end
        IWAIT: begin
          if (mem.imem_rvalid) begin
            state <= DECODE;
          end else if (to_hit) begin
            state    <= HALT;
            err_code <= ERR_IMEM;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DECODE: begin
          if (is_illegal) begin
            state    <= HALT;
            err_code <= ERR_ILL;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_mem)         state <= MEM;
          else if (is_branch) state <= after_retire;
          else                state <= WB;
        end
        MEM: begin
          if (mem.dmem_gnt) begin
            state  <= MWAIT;
            to_cnt <= '0;
          end
        end
        MWAIT: begin
          if (mem.dmem_rvalid) begin
            state <= is_store ? after_retire : WB;
          end else if (to_hit) begin
            state    <= HALT;
            err_code <= ERR_DMEM;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        WB:      state <= after_retire;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: bench-side memory responder with per-instruction latencies.
// Expected cycle counts and strobe totals come from per-class arithmetic over the latencies.
// Directed scenarios first, then randomized instruction streams.
module tb_core_seq_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 10;
  localparam int TO_W    = 4;
  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_JMP = 4, C_ILL = 5;

  logic clk = 1'b0;
  logic rst_n, run, ir_we, pc_we, pc_sel, rf_we, halted;
  logic is_load, is_store, is_branch, is_jump, is_illegal, br_taken;
  logic [1:0] err_code;
  logic [CNT_W-1:0] retired;

  core_seq_ctrl_if bus();

  core_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mem(bus), .ir_we(ir_we),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .is_illegal(is_illegal), .br_taken(br_taken), .pc_we(pc_we), .pc_sel(pc_sel),
    .rf_we(rf_we), .halted(halted), .err_code(err_code), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ret = 0;
  // memory responder latencies and progress
  int i_gl, i_rl, d_gl, d_rl, i_wait, i_rc, d_wait, d_rc;
  bit i_pend, d_pend;
  // per-instruction observations
  int n_cyc, n_ireq, n_irwe, n_dreq, n_dwe, n_rfwe, n_pcwe;
  logic last_sel;
  bit started, saw_halt, saw_pcwe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_resp();
    i_wait = 0; i_rc = 0; i_pend = 0; d_wait = 0; d_rc = 0; d_pend = 0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
  endtask

  // One clock: drive responses on the falling edge, observe 2 time units later.
  task automatic cycle();
    @(negedge clk);
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
    if (i_pend) begin i_rc++; if (i_rc == i_rl) begin bus.imem_rvalid = 1; i_pend = 0; end end
    if (bus.imem_req === 1'b1) begin
      if (i_wait == i_gl) begin bus.imem_gnt = 1; i_wait = 0; i_pend = 1; i_rc = 0; end
      else i_wait++;
    end
    if (d_pend) begin d_rc++; if (d_rc == d_rl) begin bus.dmem_rvalid = 1; d_pend = 0; end end
    if (bus.dmem_req === 1'b1) begin
      if (d_wait == d_gl) begin bus.dmem_gnt = 1; d_wait = 0; d_pend = 1; d_rc = 0; end
      else d_wait++;
    end
    #2;
    saw_pcwe = 0;
    if (bus.imem_req === 1'b1) started = 1;
    if (halted === 1'b1) saw_halt = 1;
    else if (started) begin
      n_cyc++;
      n_ireq += int'(bus.imem_req);
      n_irwe += int'(ir_we);
      n_dreq += int'(bus.dmem_req);
      n_dwe  += int'(bus.dmem_req & bus.dmem_we);
      n_rfwe += int'(rf_we);
      if (pc_we === 1'b1) begin n_pcwe++; last_sel = pc_sel; saw_pcwe = 1; end
    end
  endtask

  task automatic do_reset();
    rst_n = 0; run = 0; br_taken = 0;
    is_load = 0; is_store = 0; is_branch = 0; is_jump = 0; is_illegal = 0;
    clr_resp();
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_strobes", {ir_we, pc_we, rf_we, halted}, 0);
    chk("rst_err", err_code, 0);
    chk("rst_retired", retired, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    exp_ret = 0;
  endtask

  // One instruction through the responder; expectations from per-class latency sums.
  task automatic do_instr(input string nm, input int cls, input bit tk, input int igd,
                          input int ird, input int dgd, input int drd, input bit keep);
    int fetch, base, e_cyc, e_irwe, e_dreq, e_dwe, e_rf, e_pc, e_err;
    bit e_halt, e_sel, done;
    is_load = (cls == C_LOAD); is_store = (cls == C_STORE); is_branch = (cls == C_BR);
    is_jump = (cls == C_JMP); is_illegal = (cls == C_ILL); br_taken = tk;
    i_gl = igd; i_rl = ird; d_gl = dgd; d_rl = drd;
    n_cyc = 0; n_ireq = 0; n_irwe = 0; n_dreq = 0; n_dwe = 0; n_rfwe = 0; n_pcwe = 0;
    last_sel = 0; started = 0; saw_halt = 0; done = 0;
    run = 1;
    for (int k = 0; k < 400 && !done; k++) begin
      cycle();
      if (started && !keep) run = 0;
      if (saw_halt || saw_pcwe) done = 1;
    end
    if (!done) chk({nm, "_budget"}, 0, 1);

    fetch = igd + 1;
    e_irwe = 1; e_dreq = 0; e_dwe = 0; e_rf = 0; e_pc = 0; e_sel = 0; e_halt = 0; e_err = 0;
    base = fetch + ird;
    if (ird > TIMEOUT) begin
      e_cyc = fetch + TIMEOUT; e_irwe = 0; e_halt = 1; e_err = 2;
    end else if (cls == C_ILL) begin
      e_cyc = base + 1; e_halt = 1; e_err = 1;
    end else if (cls == C_BR) begin
      e_cyc = base + 2; e_pc = 1; e_sel = tk;
    end else if (cls == C_LOAD || cls == C_STORE) begin
      e_dreq = dgd + 1;
      e_dwe  = (cls == C_STORE) ? dgd + 1 : 0;
      if (drd > TIMEOUT) begin
        e_cyc = base + 2 + e_dreq + TIMEOUT; e_halt = 1; e_err = 3;
      end else if (cls == C_LOAD) begin
        e_cyc = base + 2 + e_dreq + drd + 1; e_rf = 1; e_pc = 1;
      end else begin
        e_cyc = base + 2 + e_dreq + drd; e_pc = 1;
      end
    end else begin
      e_cyc = base + 3; e_rf = 1; e_pc = 1; e_sel = (cls == C_JMP);
    end

    chk({nm, "_cycles"}, n_cyc, e_cyc);
    chk({nm, "_imem_req"}, n_ireq, fetch);
    chk({nm, "_ir_we"}, n_irwe, e_irwe);
    chk({nm, "_dmem_req"}, n_dreq, e_dreq);
    chk({nm, "_dmem_we"}, n_dwe, e_dwe);
    chk({nm, "_rf_we"}, n_rfwe, e_rf);
    chk({nm, "_pc_we"}, n_pcwe, e_pc);
    if (e_pc == 1) chk({nm, "_pc_sel"}, last_sel, e_sel);
    chk({nm, "_halted"}, saw_halt, e_halt);
    if (e_halt) begin
      chk({nm, "_err"}, err_code, e_err);
      chk({nm, "_retired_hold"}, retired, exp_ret);
    end else begin
      @(posedge clk); #1;
      exp_ret = (exp_ret + 1) % (1 << CNT_W);
      chk({nm, "_retired"}, retired, exp_ret);
    end
  endtask

  initial begin
    int idle_act, cls, pick;
    do_reset();

    do_instr("alu0", C_ALU, 0, 0, 1, 0, 1, 1);
    do_instr("load_slow", C_LOAD, 0, 0, 1, 3, 2, 1);
    do_instr("br_t", C_BR, 1, 0, 1, 0, 1, 1);
    do_instr("br_nt", C_BR, 0, 0, 1, 0, 1, 1);
    do_instr("st1", C_STORE, 0, 1, 2, 0, 1, 1);
    do_instr("st2", C_STORE, 0, 0, 1, 2, 1, 1);
    do_instr("ill", C_ILL, 0, 0, 1, 0, 1, 1);
    // HALT ignores run
    for (int k = 0; k < 6; k++) begin
      run = k[0];
      cycle();
    end
    chk("halt_sticky", halted, 1);
    chk("halt_no_fetch", bus.imem_req, 0);
    chk("halt_err", err_code, 1);
    chk("halt_retired", retired, 6);

    do_reset();
    do_instr("imem_to", C_ALU, 0, 1, TIMEOUT + 5, 0, 1, 1);
    do_reset();
    do_instr("dmem_to", C_LOAD, 0, 0, 1, 1, TIMEOUT + 5, 1);

    // run dropped mid-instruction: completes, then stays idle
    do_reset();
    do_instr("jmp_stop", C_JMP, 0, 1, 2, 0, 1, 0);
    idle_act = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      idle_act += int'(bus.imem_req) + int'(pc_we) + int'(halted);
    end
    chk("stop_idle", idle_act, 0);

    // 15 retires, then reset in MWAIT with a response still outstanding
    do_reset();
    for (int k = 0; k < 15; k++) do_instr("pre", C_ALU, 0, 0, 1, 0, 1, 1);
    chk("pre15", retired, 15);
    is_load = 1; is_store = 0; is_branch = 0; is_jump = 0; is_illegal = 0;
    i_gl = 0; i_rl = 1; d_gl = 0; d_rl = 5; run = 1;
    idle_act = 0;
    for (int k = 0; k < 30 && idle_act == 0; k++) begin
      cycle();
      if (bus.dmem_req === 1'b1) idle_act = 1;
    end
    chk("reach_mem", idle_act, 1);
    cycle();
    rst_n = 0; run = 0;
    #1;
    chk("arst_dmem_req", bus.dmem_req, 0);
    chk("arst_imem_req", bus.imem_req, 0);
    chk("arst_retired", retired, 0);
    chk("arst_misc", {halted, err_code, pc_we, rf_we}, 0);
    @(negedge clk); rst_n = 1; exp_ret = 0;
    idle_act = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      idle_act += int'(bus.imem_req) + int'(bus.dmem_req) + int'(pc_we) + int'(ir_we);
    end
    chk("late_rvalid_idle", idle_act, 0);
    chk("late_retired", retired, 0);
    clr_resp();
    for (int k = 0; k < 16; k++) do_instr("wrap", C_ALU, 0, 0, 1, 0, 1, 1);
    chk("wrap16", retired, 0);

    // randomized stream
    do_reset();
    for (int k = 0; k < 40; k++) begin
      pick = $urandom_range(0, 4);
      cls = (pick == 0) ? C_ALU : (pick == 1) ? C_LOAD : (pick == 2) ? C_STORE :
            (pick == 3) ? C_BR : C_JMP;
      do_instr("rnd", cls, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 4),
               $urandom_range(0, 5) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
